// File: rtl/inst_fetch_responder_pkg.sv
// Shared definitions for the instruction fetch responder: state encoding,
// bus constants and the kseg0/kseg1 physical address mapping.
package inst_fetch_responder_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 2;

    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR1  = 3'd1,
        ST_ADDR2  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4,
        ST_CANCEL = 3'd5
    } fetch_state_e;

    // kseg0 (0x8xxx_xxxx) and kseg1 (0xBxxx_xxxx) fold onto the low physical range
    function automatic logic [XLEN-1:0] map_paddr(input logic [XLEN-1:0] vaddr);
        logic [XLEN-1:0] paddr;
        paddr = vaddr;
        case (vaddr[31:28])
            4'h8:    paddr = {4'h0, vaddr[27:0]};
            4'hB:    paddr = {4'h1, vaddr[27:0]};
            default: paddr = vaddr;
        endcase
        return paddr;
    endfunction

endpackage

// File: rtl/fetch_addr_map.sv
// Combinational virtual-to-physical translation for the fetch bus address.
module fetch_addr_map
    import inst_fetch_responder_pkg::*;
#(
    parameter bit ADDR_MAP = 1'b1
) (
    input  logic [XLEN-1:0] vaddr,
    output logic [XLEN-1:0] paddr
);

    assign paddr = ADDR_MAP ? map_paddr(vaddr) : vaddr;

endmodule

// File: rtl/inst_fetch_responder.sv
// Memory-side responder for the dual-issue fetch interface: two pipelined word
// reads (pc, pc+4) per request, delivered together with per-slot valid flags.
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter bit ADDR_MAP = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_sram_en,
    input  logic [XLEN-1:0] F_pc,
    input  logic            flush,
    output logic            inst_data_ok,
    output logic            inst_data_ok1,
    output logic            inst_data_ok2,
    output logic [XLEN-1:0] inst_rdata1,
    output logic [XLEN-1:0] inst_rdata2,
    output logic            fetch_adel,
    output logic            i_stall,
    output logic            mem_req,
    output logic            mem_wr,
    output logic [1:0]      mem_size,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_addr_ok,
    input  logic            mem_data_ok,
    input  logic [XLEN-1:0] mem_rdata
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            adel_q, adel_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] rcvd_q, rcvd_d;
    logic            wr_slot1, wr_slot2;
    logic [XLEN-1:0] vaddr;
    logic            in_addr;
    logic            addr_beat;
    logic            data_beat;

    assign mem_wr   = 1'b0;
    assign mem_size = MEM_SIZE_WORD;

    assign in_addr   = (state_q == ST_ADDR1) || (state_q == ST_ADDR2);
    assign addr_beat = in_addr & mem_addr_ok;
    // Only count data for beats already issued; protects the counters from a stray data_ok
    assign data_beat = mem_data_ok & (rcvd_q != issued_q) &
                       ((state_q == ST_ADDR2) || (state_q == ST_WAIT) || (state_q == ST_CANCEL));

    assign i_stall = in_addr || (state_q == ST_WAIT) || (state_q == ST_CANCEL) ||
                     ((state_q == ST_IDLE) && inst_sram_en);

    fetch_addr_map #(
        .ADDR_MAP (ADDR_MAP)
    ) u_addr_map (
        .vaddr (vaddr),
        .paddr (mem_addr)
    );

    // Next-state, counters, bus request and delivery outputs
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        adel_d        = adel_q;
        issued_d      = issued_q + CNT_W'(addr_beat);
        rcvd_d        = rcvd_q + CNT_W'(data_beat);
        wr_slot1      = 1'b0;
        wr_slot2      = 1'b0;
        mem_req       = 1'b0;
        vaddr         = pc_q;
        inst_data_ok  = 1'b0;
        inst_data_ok1 = 1'b0;
        inst_data_ok2 = 1'b0;
        fetch_adel    = 1'b0;

        if (in_addr) begin
            mem_req = ~flush | mem_addr_ok;
        end
        if (state_q == ST_ADDR2) begin
            vaddr = pc_q + 32'd4;
        end
        // A flushed fetch never updates the delivered words
        if (data_beat && !flush && (state_q != ST_CANCEL)) begin
            wr_slot1 = (rcvd_q == CNT_W'(0));
            wr_slot2 = (rcvd_q == CNT_W'(1));
        end

        case (state_q)
            ST_IDLE: begin
                if (inst_sram_en && !flush) begin
                    pc_d     = F_pc;
                    issued_d = '0;
                    rcvd_d   = '0;
                    if (F_pc[1:0] != 2'b00) begin
                        adel_d  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        adel_d  = 1'b0;
                        state_d = ST_ADDR1;
                    end
                end
            end
            ST_ADDR1: begin
                if (flush) begin
                    state_d = (issued_d != rcvd_d) ? ST_CANCEL : ST_IDLE;
                end else if (mem_addr_ok) begin
                    state_d = ST_ADDR2;
                end
            end
            ST_ADDR2: begin
                if (flush) begin
                    state_d = (issued_d != rcvd_d) ? ST_CANCEL : ST_IDLE;
                end else if (mem_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = (issued_d != rcvd_d) ? ST_CANCEL : ST_IDLE;
                end else if (rcvd_d == CNT_W'(2)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                inst_data_ok  = ~flush;
                inst_data_ok1 = ~adel_q;
                inst_data_ok2 = ~adel_q;
                fetch_adel    = adel_q;
                state_d       = ST_IDLE;
            end
            ST_CANCEL: begin
                if (issued_d == rcvd_d) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            adel_q      <= 1'b0;
            issued_q    <= '0;
            rcvd_q      <= '0;
            inst_rdata1 <= '0;
            inst_rdata2 <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            adel_q   <= adel_d;
            issued_q <= issued_d;
            rcvd_q   <= rcvd_d;
            if (wr_slot1) begin
                inst_rdata1 <= mem_rdata;
            end
            if (wr_slot2) begin
                inst_rdata2 <= mem_rdata;
            end
        end
    end

endmodule
